// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch queue.
package fetch_pkg;

    localparam int FQ_N_WAY    = 3;
    localparam int FQ_DEPTH    = 16;
    localparam int FQ_XLEN     = 32;
    localparam int FQ_PTR_W    = $clog2(FQ_DEPTH);
    localparam int FQ_CNT_W    = $clog2(FQ_DEPTH) + 1;
    localparam int FQ_LANE_W   = $clog2(FQ_N_WAY) + 1;
    localparam int INSN_STRIDE = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] addr;
        logic [FQ_XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/valid_prefix.sv
// Length of the contiguous run of set bits starting at lane 0, plus a flag
// that is low when any set bit lies beyond that run.
module valid_prefix #(
    parameter int N_WAY = 3,
    parameter int LEN_W = $clog2(N_WAY) + 1
) (
    input  logic [N_WAY-1:0] valid_i,
    output logic [LEN_W-1:0] len_o,
    output logic             contig_o
);

    logic run;

    always_comb begin
        len_o    = '0;
        contig_o = 1'b1;
        run      = 1'b1;
        for (int i = 0; i < N_WAY; i++) begin
            if (valid_i[i]) begin
                if (run) len_o = len_o + LEN_W'(1);
                else     contig_o = 1'b0;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between the Icache and dispatch, with
// epoch-tagged responses, fetch-PC checking and space-limited requests.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              N_WAY    = FQ_N_WAY,
    parameter int              DEPTH    = FQ_DEPTH,
    parameter int              XLEN     = FQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [N_WAY*XLEN-1:0]       Icache2fq_addr,
    input  logic [N_WAY*XLEN-1:0]       Icache2fq_data,
    input  logic [N_WAY-1:0]            Icache2fq_valid,
    input  logic                        Icache2fq_epoch,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_addr,
    input  logic [$clog2(N_WAY):0]      proc2fq_dispatch_count,
    output logic [XLEN-1:0]             fq2Icache_addr,
    output logic [$clog2(N_WAY):0]      fq2Icache_count,
    output logic                        fq2Icache_epoch,
    output logic [N_WAY*XLEN-1:0]       fq2proc_addr,
    output logic [N_WAY*XLEN-1:0]       fq2proc_data,
    output logic [N_WAY-1:0]            fq2proc_valid,
    output logic [$clog2(DEPTH):0]      fq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(N_WAY) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] N_WAY_C = CW'(N_WAY);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic            epoch_q;
    logic [LW-1:0]   inflight_q, req_q, req_d;

    logic [LW-1:0]   prefix_len;
    logic            prefix_contig;
    logic            accept;
    logic [CW-1:0]   free, free_d, fill, pop, pop_lim, disp;

    valid_prefix #(.N_WAY(N_WAY), .LEN_W(LW)) u_prefix (
        .valid_i  (Icache2fq_valid),
        .len_o    (prefix_len),
        .contig_o (prefix_contig)
    );

    always_comb begin
        accept = enable && !redirect_valid && (Icache2fq_epoch == epoch_q) &&
                 prefix_contig && (Icache2fq_addr[XLEN-1:0] == fetch_pc_q);
        free   = DEPTH_C - count_q;
        fill   = '0;
        // Space is judged on the start-of-cycle count; slots freed by this cycle's pop wait a cycle.
        if (accept) fill = (CW'(prefix_len) < free) ? CW'(prefix_len) : free;
        disp    = CW'(proc2fq_dispatch_count);
        pop_lim = (count_q < N_WAY_C) ? count_q : N_WAY_C;
        pop     = (disp < pop_lim) ? disp : pop_lim;
        count_d = count_q + fill - pop;
        free_d  = DEPTH_C - count_d;
        if (free_d >= N_WAY_C)     req_d = LW'(N_WAY);
        else if (inflight_q != '0) req_d = '0;
        else                       req_d = LW'(free_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            inflight_q <= '0;
            req_q      <= LW'(N_WAY);
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enable) begin
            if (redirect_valid) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= redirect_addr;
                epoch_q    <= ~epoch_q;
                inflight_q <= '0;
                req_q      <= LW'(N_WAY);
            end else begin
                for (int i = 0; i < N_WAY; i++) begin
                    if (CW'(i) < fill) begin
                        mem_q[tail_q + PW'(i)].addr <= Icache2fq_addr[i*XLEN +: XLEN];
                        mem_q[tail_q + PW'(i)].data <= Icache2fq_data[i*XLEN +: XLEN];
                    end
                end
                head_q     <= head_q + pop[PW-1:0];
                tail_q     <= tail_q + fill[PW-1:0];
                count_q    <= count_d;
                fetch_pc_q <= fetch_pc_q + (XLEN'(fill) * XLEN'(INSN_STRIDE));
                inflight_q <= req_q;
                req_q      <= req_d;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            fq2proc_addr[i*XLEN +: XLEN] = mem_q[head_q + PW'(i)].addr;
            fq2proc_data[i*XLEN +: XLEN] = mem_q[head_q + PW'(i)].data;
            fq2proc_valid[i]             = count_q > CW'(i);
        end
    end

    assign fq2Icache_addr  = fetch_pc_q;
    assign fq2Icache_count = req_q;
    assign fq2Icache_epoch = epoch_q;
    assign fq_count        = count_q;

    // Dispatch asking for more than a full group is a caller bug; it is clamped above.
    assert property (@(posedge clock) disable iff (reset)
        (enable && !redirect_valid) |-> (proc2fq_dispatch_count <= LW'(N_WAY)))
        else $error("proc2fq_dispatch_count exceeds N_WAY");

endmodule
